enc_seq_ctrl: RTL

Job sequencer for the encryption core. Latches a key from the key_in register bank and a data block from the data_in register bank, starts the cipher datapath and waits for its result. It then fires the data_out AXI master (INIT_AXI_TXN / TXN_DONE / ERROR) to write the result out. Sits between the two AXI-lite slave register banks, the cipher datapath and the data_out master inside the core wrapper, and holds one data block pending while a job is in flight.

---
 rtl/enc_seq_pkg.sv | 18 +
 rtl/enc_seq_pend_buf.sv | 33 +++
 rtl/enc_seq_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/enc_seq_pkg.sv
// enc_seq_pkg: shared state encoding, status bit positions and default block sizes
// for the encryption job sequencer.
package enc_seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYED,
      S_WAIT_CORE,
      S_XFER,
      S_WAIT_XFER,
      S_ERR
   } state_t;
   localparam int ST_NO_KEY      = 0;
   localparam int ST_KEY_OVR     = 1;
   localparam int ST_DATA_OVR    = 2;
   localparam int ST_TIMEOUT     = 3;
   localparam int DEF_DATA_WORDS = 4;
   localparam int DEF_KEY_WORDS  = 4;
endpackage

// File: rtl/enc_seq_pend_buf.sv
// enc_seq_pend_buf: one-entry data block buffer with valid flag; ovf pulses when
// a push finds it full and nothing is leaving in the same cycle.
module enc_seq_pend_buf
   import enc_seq_pkg::*;
#(
   parameter int W = 32 * DEF_DATA_WORDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic         ovf
);
   assign ovf = push && valid && !pop && !flush;
   // A push alongside a pop refills the slot with the new block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (push && (!valid || pop)) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/enc_seq_ctrl.sv
// enc_seq_ctrl: key/data latch, cipher start and data_out write-back sequencer.
// Define ENC_SEQ_TIMEOUT_EN to add the S_WAIT_CORE watchdog (TIMEOUT_CYCLES).
module enc_seq_ctrl
   import enc_seq_pkg::*;
#(
   parameter int DATA_WORDS = DEF_DATA_WORDS,
   parameter int KEY_WORDS  = DEF_KEY_WORDS,
`ifdef ENC_SEQ_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 1024,
`endif
   parameter int CNT_W = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    key_load,
   input  logic [32*KEY_WORDS-1:0] key_words,
   input  logic                    data_load,
   input  logic [32*DATA_WORDS-1:0] data_words,
   output logic [32*KEY_WORDS-1:0] core_key,
   output logic [32*DATA_WORDS-1:0] core_data,
   output logic                    core_start,
   input  logic                    core_done,
   input  logic [32*DATA_WORDS-1:0] core_result,
   output logic [32*DATA_WORDS-1:0] result,
   output logic                    INIT_AXI_TXN,
   input  logic                    TXN_DONE,
   input  logic                    ERROR,
   input  logic                    clear_err,
   output logic                    busy,
   output logic                    job_done,
   output logic                    err,
   output logic [3:0]              status,
   output logic [CNT_W-1:0]        job_count
);
   state_t state, nxt;
   logic key_valid, busy_st, start_pend, start, core_fin, txn_ok, to_err, tmo, push;
   logic pb_valid, pb_ovf;
   logic [32*DATA_WORDS-1:0] pb_dout;
   logic [3:0] set_bits;
   assign busy_st    = state inside {S_WAIT_CORE, S_XFER, S_WAIT_XFER};
   assign start_pend = state == S_KEYED && pb_valid;
   assign start      = state == S_KEYED && (pb_valid || data_load);
   assign core_fin   = state == S_WAIT_CORE && core_done;
   assign txn_ok     = state == S_WAIT_XFER && TXN_DONE && !ERROR;
   assign to_err     = (state == S_WAIT_XFER && TXN_DONE && ERROR) || tmo;
   // A block arriving while the pending one is being started takes its place.
   assign push       = data_load && (busy_st || start_pend);
`ifdef ENC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WD_W-1:0] wd;
   assign tmo = state == S_WAIT_CORE && !core_done && wd == WD_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) wd <= '0;
      else wd <= state == S_WAIT_CORE ? wd + 1'b1 : '0;
   end
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      set_bits = '0;
      set_bits[ST_NO_KEY]   = data_load && state == S_IDLE;
      set_bits[ST_KEY_OVR]  = key_load && busy_st;
      set_bits[ST_DATA_OVR] = pb_ovf;
      set_bits[ST_TIMEOUT]  = tmo;
   end
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:      nxt = key_load ? S_KEYED : S_IDLE;
         S_KEYED:     nxt = start ? S_WAIT_CORE : S_KEYED;
         S_WAIT_CORE: nxt = core_done ? S_XFER : tmo ? S_ERR : S_WAIT_CORE;
         S_XFER:      nxt = S_WAIT_XFER;
         S_WAIT_XFER: nxt = !TXN_DONE ? S_WAIT_XFER : ERROR ? S_ERR : S_KEYED;
         S_ERR:       nxt = !clear_err ? S_ERR : key_valid ? S_KEYED : S_IDLE;
         default:     nxt = S_IDLE;
      endcase
   end
   enc_seq_pend_buf #(.W(32 * DATA_WORDS)) u_pend (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .push  (push),
      .pop   (start_pend),
      .flush (to_err),
      .din   (data_words),
      .valid (pb_valid),
      .dout  (pb_dout),
      .ovf   (pb_ovf)
   );
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state        <= S_IDLE;
         key_valid    <= 1'b0;
         core_key     <= '0;
         core_data    <= '0;
         core_start   <= 1'b0;
         result       <= '0;
         INIT_AXI_TXN <= 1'b0;
         busy         <= 1'b0;
         job_done     <= 1'b0;
         err          <= 1'b0;
         status       <= '0;
         job_count    <= '0;
      end else begin
         state        <= nxt;
         core_start   <= start;
         INIT_AXI_TXN <= core_fin;
         job_done     <= txn_ok;
         busy         <= nxt inside {S_WAIT_CORE, S_XFER, S_WAIT_XFER};
         err          <= nxt == S_ERR;
         status       <= (clear_err ? 4'b0 : status) | set_bits;
         if (key_load && !busy_st) begin
            core_key  <= key_words;
            key_valid <= 1'b1;
         end
         if (start) core_data <= start_pend ? pb_dout : data_words;
         if (core_fin) result <= core_result;
         if (txn_ok) job_count <= job_count + 1'b1;
      end
   end
endmodule
